// File: rtl/riscv_trace_buffer_if.sv
// Retire-trace port bundle: retire beat and control toward the buffer,
// head record and status back toward the consumer/debug side.
interface riscv_trace_buffer_if #(
   parameter int dwidth = 64,
   parameter int iwidth = 32,
   parameter int awidth = 5,
   parameter int cwidth = 16,
   parameter int DEPTH  = 8
);
   localparam int RW = 4*dwidth + iwidth + cwidth + awidth;
   localparam int CW = $clog2(DEPTH + 1);

   // capture control
   logic              i_riscv_trc_en;
   logic              i_riscv_trc_mode;
   logic              i_riscv_trc_clr;
   logic              i_riscv_trc_trig_en;
   logic [dwidth-1:0] i_riscv_trc_trig_pc;

   // retire beat
   logic              i_riscv_trc_valid;
   logic [iwidth-1:0] i_riscv_trc_inst;
   logic [cwidth-1:0] i_riscv_trc_cinst;
   logic [awidth-1:0] i_riscv_trc_rdaddr;
   logic [dwidth-1:0] i_riscv_trc_pc;
   logic [dwidth-1:0] i_riscv_trc_memaddr;
   logic [dwidth-1:0] i_riscv_trc_store;
   logic [dwidth-1:0] i_riscv_trc_rddata;

   // drain handshake
   logic              i_riscv_trc_rec_ready;
   logic              o_riscv_trc_rec_valid;
   logic [RW-1:0]     o_riscv_trc_rec;

   // status
   logic [CW-1:0]     o_riscv_trc_count;
   logic              o_riscv_trc_full;
   logic              o_riscv_trc_empty;
   logic              o_riscv_trc_overflow;
   logic [15:0]       o_riscv_trc_drop_cnt;
   logic              o_riscv_trc_frozen;

   modport master (
      output i_riscv_trc_en, i_riscv_trc_mode, i_riscv_trc_clr,
      output i_riscv_trc_trig_en, i_riscv_trc_trig_pc,
      output i_riscv_trc_valid, i_riscv_trc_inst, i_riscv_trc_cinst,
      output i_riscv_trc_rdaddr, i_riscv_trc_pc, i_riscv_trc_memaddr,
      output i_riscv_trc_store, i_riscv_trc_rddata, i_riscv_trc_rec_ready,
      input  o_riscv_trc_rec_valid, o_riscv_trc_rec, o_riscv_trc_count,
      input  o_riscv_trc_full, o_riscv_trc_empty, o_riscv_trc_overflow,
      input  o_riscv_trc_drop_cnt, o_riscv_trc_frozen
   );

   modport slave (
      input  i_riscv_trc_en, i_riscv_trc_mode, i_riscv_trc_clr,
      input  i_riscv_trc_trig_en, i_riscv_trc_trig_pc,
      input  i_riscv_trc_valid, i_riscv_trc_inst, i_riscv_trc_cinst,
      input  i_riscv_trc_rdaddr, i_riscv_trc_pc, i_riscv_trc_memaddr,
      input  i_riscv_trc_store, i_riscv_trc_rddata, i_riscv_trc_rec_ready,
      output o_riscv_trc_rec_valid, o_riscv_trc_rec, o_riscv_trc_count,
      output o_riscv_trc_full, o_riscv_trc_empty, o_riscv_trc_overflow,
      output o_riscv_trc_drop_cnt, o_riscv_trc_frozen
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Circular retire-trace buffer with stop/overwrite capture, PC trigger with
// post-trigger freeze, and a valid/ready drain port for the trace consumer.
module riscv_trace_buffer #(
   parameter int dwidth = 64,
   parameter int iwidth = 32,
   parameter int awidth = 5,
   parameter int cwidth = 16,
   parameter int DEPTH  = 8,
   parameter int POST   = 4
) (
   input  logic                i_riscv_clk,
   input  logic                i_riscv_rst,
   riscv_trace_buffer_if.slave trc
);
   localparam int RW = 4*dwidth + iwidth + cwidth + awidth;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] POST_C  = CW'(POST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_POST, ST_FROZEN} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] post_cnt_q, post_cnt_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic [RW-1:0] mem_q [DEPTH];

   logic          capture;
   logic          frozen;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          trig_hit;
   logic          wr_en;
   logic [RW-1:0] rec_in;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign push     = trc.i_riscv_trc_valid & capture;
   assign pop      = ~empty & trc.i_riscv_trc_rec_ready;
   assign trig_hit = trc.i_riscv_trc_trig_en &
                     (trc.i_riscv_trc_pc == trc.i_riscv_trc_trig_pc);

   assign rec_in = {trc.i_riscv_trc_pc, trc.i_riscv_trc_inst,
                    trc.i_riscv_trc_cinst, trc.i_riscv_trc_rdaddr,
                    trc.i_riscv_trc_rddata, trc.i_riscv_trc_memaddr,
                    trc.i_riscv_trc_store};

   // FSM state register
   always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
      if (i_riscv_rst) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // FSM next state: clr restarts capture from any state; disable wins over trigger
   always_comb begin
      state_d = state_q;
      if (trc.i_riscv_trc_clr) begin
         state_d = trc.i_riscv_trc_en ? ST_RUN : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (trc.i_riscv_trc_en) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!trc.i_riscv_trc_en)    state_d = ST_IDLE;
               else if (push && trig_hit)  state_d = (POST == 0) ? ST_FROZEN : ST_POST;
            end
            ST_POST: begin
               if (!trc.i_riscv_trc_en)               state_d = ST_IDLE;
               else if (push && post_cnt_q == CNT_ONE) state_d = ST_FROZEN;
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: capture window and frozen flag
   always_comb begin
      capture = 1'b0;
      frozen  = 1'b0;
      case (state_q)
         ST_RUN, ST_POST: capture = 1'b1;
         ST_FROZEN:       frozen  = 1'b1;
         default:         ;
      endcase
   end

   // Datapath next state: pointers, occupancy, post-trigger count, loss tracking
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      post_cnt_d = post_cnt_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      wr_en      = 1'b0;
      if (trc.i_riscv_trc_clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         post_cnt_d = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         // dropped beats still advance the trigger/post count, keeping freeze in retire order
         if (push) begin
            if (state_q == ST_RUN && trig_hit)
               post_cnt_d = POST_C;
            else if (state_q == ST_POST && post_cnt_q != '0)
               post_cnt_d = post_cnt_q - CNT_ONE;
         end
         if (push) begin
            if (full && !pop && !trc.i_riscv_trc_mode) begin
               overflow_d = 1'b1;
               if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (full && !pop) begin
                  // overwrite oldest: wr_ptr == rd_ptr when full, so read side moves too
                  rd_ptr_d   = rd_ptr_q + PTR_ONE;
                  overflow_d = 1'b1;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               end else if (!pop) begin
                  count_d = count_q + CNT_ONE;
               end
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (!push) count_d = count_q - CNT_ONE;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
      if (i_riscv_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         post_cnt_q <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         post_cnt_q <= post_cnt_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Record storage; contents are don't-care until written
   always_ff @(posedge i_riscv_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= rec_in;
   end

   assign trc.o_riscv_trc_rec_valid = ~empty;
   assign trc.o_riscv_trc_rec       = empty ? '0 : mem_q[rd_ptr_q];
   assign trc.o_riscv_trc_count     = count_q;
   assign trc.o_riscv_trc_full      = full;
   assign trc.o_riscv_trc_empty     = empty;
   assign trc.o_riscv_trc_overflow  = overflow_q;
   assign trc.o_riscv_trc_drop_cnt  = drop_cnt_q;
   assign trc.o_riscv_trc_frozen    = frozen;
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Randomized and directed bench for riscv_trace_buffer against a queue-based reference model.
module tb_riscv_trace_buffer;
   localparam int DW    = 64;
   localparam int IW    = 32;
   localparam int AWD   = 5;
   localparam int CWD   = 16;
   localparam int DEPTH = 4;
   localparam int POST  = 2;
   localparam int RW    = 4*DW + IW + CWD + AWD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   riscv_trace_buffer_if #(.dwidth(DW), .iwidth(IW), .awidth(AWD), .cwidth(CWD),
                           .DEPTH(DEPTH)) bus ();

   riscv_trace_buffer #(.dwidth(DW), .iwidth(IW), .awidth(AWD), .cwidth(CWD),
                        .DEPTH(DEPTH), .POST(POST)) dut (
      .i_riscv_clk (clk),
      .i_riscv_rst (rst),
      .trc         (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: FIFO of records plus capture/trigger flags
   logic [RW-1:0] mq[$];
   bit            m_active;
   bit            m_frozen;
   bit            m_ovf;
   int            m_post_left;
   int            m_drops;

   task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_active    = 1'b0;
      m_frozen    = 1'b0;
      m_ovf       = 1'b0;
      m_post_left = -1;
      m_drops     = 0;
   endtask

   task automatic model_step();
      bit            pop;
      bit            push;
      logic [RW-1:0] r;
      pop = (mq.size() != 0) && bus.i_riscv_trc_rec_ready;
      if (bus.i_riscv_trc_clr) begin
         mq.delete();
         m_ovf       = 1'b0;
         m_drops     = 0;
         m_post_left = -1;
         m_frozen    = 1'b0;
         m_active    = bus.i_riscv_trc_en;
         return;
      end
      push = bus.i_riscv_trc_valid && m_active;
      r = {bus.i_riscv_trc_pc, bus.i_riscv_trc_inst, bus.i_riscv_trc_cinst,
           bus.i_riscv_trc_rdaddr, bus.i_riscv_trc_rddata, bus.i_riscv_trc_memaddr,
           bus.i_riscv_trc_store};
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < DEPTH) mq.push_back(r);
         else begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
            if (bus.i_riscv_trc_mode) begin
               void'(mq.pop_front());
               mq.push_back(r);
            end
         end
      end
      if (m_active) begin
         if (!bus.i_riscv_trc_en) begin
            m_active    = 1'b0;
            m_post_left = -1;
         end else if (push) begin
            if (m_post_left > 0) begin
               m_post_left--;
               if (m_post_left == 0) begin
                  m_frozen    = 1'b1;
                  m_active    = 1'b0;
                  m_post_left = -1;
               end
            end else if (bus.i_riscv_trc_trig_en && bus.i_riscv_trc_pc == bus.i_riscv_trc_trig_pc) begin
               if (POST == 0) begin
                  m_frozen = 1'b1;
                  m_active = 1'b0;
               end else m_post_left = POST;
            end
         end
      end else if (!m_frozen && bus.i_riscv_trc_en) m_active = 1'b1;
   endtask

   function automatic logic [RW-1:0] model_head();
      if (mq.size() == 0) return '0;
      return mq[0];
   endfunction

   task automatic compare_all();
      check_eq("rec_valid", RW'(bus.o_riscv_trc_rec_valid), RW'(mq.size() != 0));
      check_eq("rec",       bus.o_riscv_trc_rec, model_head());
      check_eq("count",     RW'(bus.o_riscv_trc_count), RW'(mq.size()));
      check_eq("full",      RW'(bus.o_riscv_trc_full), RW'(mq.size() == DEPTH));
      check_eq("empty",     RW'(bus.o_riscv_trc_empty), RW'(mq.size() == 0));
      check_eq("overflow",  RW'(bus.o_riscv_trc_overflow), RW'(m_ovf));
      check_eq("drop_cnt",  RW'(bus.o_riscv_trc_drop_cnt), RW'(m_drops));
      check_eq("frozen",    RW'(bus.o_riscv_trc_frozen), RW'(m_frozen));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic beat(input logic [63:0] pc);
      bus.i_riscv_trc_valid   = 1'b1;
      bus.i_riscv_trc_pc      = pc;
      bus.i_riscv_trc_inst    = $urandom;
      bus.i_riscv_trc_cinst   = 16'($urandom);
      bus.i_riscv_trc_rdaddr  = 5'($urandom);
      bus.i_riscv_trc_rddata  = {$urandom, $urandom};
      bus.i_riscv_trc_memaddr = {$urandom, $urandom};
      bus.i_riscv_trc_store   = {$urandom, $urandom};
   endtask

   task automatic clr_pulse();
      bus.i_riscv_trc_clr = 1'b1;
      tick();
      bus.i_riscv_trc_clr = 1'b0;
   endtask

   function automatic logic [63:0] head_pc();
      logic [RW-1:0] r;
      r = bus.o_riscv_trc_rec;
      return r[RW-1 -: DW];
   endfunction

   task automatic drain_expect(input string tag, input logic [63:0] base, input int n);
      bus.i_riscv_trc_valid     = 1'b0;
      bus.i_riscv_trc_rec_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         check_eq(tag, RW'(head_pc()), RW'(base + 64'(4*i)));
         tick();
      end
      bus.i_riscv_trc_rec_ready = 1'b0;
      check_eq({tag, "_empty"}, RW'(bus.o_riscv_trc_empty), RW'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_riscv_trc_en        = 1'b0;
      bus.i_riscv_trc_mode      = 1'b0;
      bus.i_riscv_trc_clr       = 1'b0;
      bus.i_riscv_trc_trig_en   = 1'b0;
      bus.i_riscv_trc_trig_pc   = '0;
      bus.i_riscv_trc_rec_ready = 1'b0;
      beat(64'h0);
      bus.i_riscv_trc_valid     = 1'b0;
      rst = 1'b1;
      model_reset();
      #3;
      compare_all();
      @(posedge clk);
      #1 rst = 1'b0;

      // stop mode: first DEPTH beats kept, two dropped
      bus.i_riscv_trc_en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin beat(64'h100 + 64'(4*i)); tick(); end
      bus.i_riscv_trc_valid = 1'b0;
      check_eq("t1_count", RW'(bus.o_riscv_trc_count), RW'(4));
      check_eq("t1_full",  RW'(bus.o_riscv_trc_full), RW'(1));
      check_eq("t1_drops", RW'(bus.o_riscv_trc_drop_cnt), RW'(2));
      check_eq("t1_ovf",   RW'(bus.o_riscv_trc_overflow), RW'(1));
      drain_expect("t1_pc", 64'h100, 4);

      // overwrite mode: newest DEPTH beats kept
      clr_pulse();
      check_eq("t2_clr_ovf", RW'(bus.o_riscv_trc_overflow), RW'(0));
      bus.i_riscv_trc_mode = 1'b1;
      for (int i = 0; i < 6; i++) begin beat(64'h100 + 64'(4*i)); tick(); end
      bus.i_riscv_trc_valid = 1'b0;
      check_eq("t2_drops", RW'(bus.o_riscv_trc_drop_cnt), RW'(2));
      drain_expect("t2_pc", 64'h108, 4);

      // trigger at 0x208, freeze two records later
      clr_pulse();
      bus.i_riscv_trc_trig_en = 1'b1;
      bus.i_riscv_trc_trig_pc = 64'h208;
      for (int i = 0; i < 8; i++) begin
         beat(64'h200 + 64'(4*i));
         tick();
         if (i == 3) check_eq("t3_not_frozen", RW'(bus.o_riscv_trc_frozen), RW'(0));
         if (i == 4) check_eq("t3_frozen", RW'(bus.o_riscv_trc_frozen), RW'(1));
      end
      bus.i_riscv_trc_valid = 1'b0;
      check_eq("t3_count", RW'(bus.o_riscv_trc_count), RW'(4));
      check_eq("t3_drops", RW'(bus.o_riscv_trc_drop_cnt), RW'(1));
      drain_expect("t3_pc", 64'h204, 4);
      clr_pulse();
      bus.i_riscv_trc_trig_en = 1'b0;
      check_eq("t3_clr_frozen", RW'(bus.o_riscv_trc_frozen), RW'(0));
      check_eq("t3_clr_empty",  RW'(bus.o_riscv_trc_empty), RW'(1));
      beat(64'h250);
      tick();
      bus.i_riscv_trc_valid = 1'b0;
      check_eq("t3_run_capture", RW'(bus.o_riscv_trc_count), RW'(1));

      // full buffer, stop mode, simultaneous push and pop
      clr_pulse();
      bus.i_riscv_trc_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin beat(64'h400 + 64'(4*i)); tick(); end
      bus.i_riscv_trc_rec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("t4_head", RW'(head_pc()), RW'(64'h400 + 64'(4*i)));
         beat(64'h410 + 64'(4*i));
         tick();
         check_eq("t4_count", RW'(bus.o_riscv_trc_count), RW'(4));
      end
      check_eq("t4_drops", RW'(bus.o_riscv_trc_drop_cnt), RW'(0));
      drain_expect("t4_pc", 64'h40C, 4);

      // stall then one pop per cycle
      for (int i = 0; i < 3; i++) begin beat(64'h500 + 64'(4*i)); tick(); end
      bus.i_riscv_trc_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("t5_stall_pc", RW'(head_pc()), RW'(64'h500));
      end
      bus.i_riscv_trc_rec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t5_pop_count", RW'(bus.o_riscv_trc_count), RW'(2 - i));
      end
      bus.i_riscv_trc_rec_ready = 1'b0;

      // asynchronous reset mid-drain
      for (int i = 0; i < 4; i++) begin beat(64'h600 + 64'(4*i)); tick(); end
      bus.i_riscv_trc_valid     = 1'b0;
      bus.i_riscv_trc_rec_ready = 1'b1;
      tick();
      check_eq("t6_count3", RW'(bus.o_riscv_trc_count), RW'(3));
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_eq("t6_rst_count", RW'(bus.o_riscv_trc_count), RW'(0));
      check_eq("t6_rst_valid", RW'(bus.o_riscv_trc_rec_valid), RW'(0));
      check_eq("t6_rst_rec",   bus.o_riscv_trc_rec, '0);
      compare_all();
      bus.i_riscv_trc_rec_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      beat(64'h700);
      tick();
      check_eq("t6_first_edge", RW'(bus.o_riscv_trc_count), RW'(0));
      tick();
      check_eq("t6_second_edge", RW'(bus.o_riscv_trc_count), RW'(1));
      check_eq("t6_pc", RW'(head_pc()), RW'(64'h700));

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            bus.i_riscv_trc_mode    = 1'($urandom);
            bus.i_riscv_trc_trig_en = 1'($urandom);
            bus.i_riscv_trc_trig_pc = 64'(32'h100 + 32'd4 * $urandom_range(0, 15));
         end
         bus.i_riscv_trc_en        = ($urandom % 16) != 0;
         bus.i_riscv_trc_clr       = ($urandom % 50) == 0;
         bus.i_riscv_trc_rec_ready = 1'($urandom);
         if ($urandom % 3 != 0) beat(64'(32'h100 + 32'd4 * $urandom_range(0, 15)));
         else bus.i_riscv_trc_valid = 1'b0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
